// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and default sizing for the serial add/sub arbiter.
//   state_e   - controller state (IDLE, RUN, DONE)
//   W_DEF     - default operand/result width
//   SLICE_DEF - default bits processed per clock
//   NSLICE    - slices per operation at the default sizing
package addsub_pkg;
  localparam int W_DEF     = 16;
  localparam int SLICE_DEF = 4;
  localparam int NSLICE    = W_DEF / SLICE_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: purely combinational SLICE-bit ripple full-adder chain.
//   a, b      - slice operands (b already conditionally inverted for subtract)
//   cin       - carry into bit 0
//   sum       - slice sum
//   cout      - carry out of the top bit
//   c_msb_in  - carry into the top bit, used for signed overflow detection
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout     = c[SLICE];
  assign c_msb_in = c[SLICE-1];
endmodule

// File: rtl/addsub_seq_arbiter.sv
// addsub_seq_arbiter: two requesters share one SLICE-bit add/sub slice.
// Round-robin grant in IDLE; each accepted W-bit op runs LSB slice first, one
// slice per clock, then the result is held on a valid/ready response channel.
//   clk, rst                 - clock, async active-high reset
//   reqN_valid/ready         - request handshake (ready only in IDLE)
//   reqN_a, reqN_b, reqN_m   - operands, m=1 selects A-B
//   rsp_valid/ready          - response handshake
//   rsp_id, rsp_sum, rsp_cout, rsp_ovf - result owner, sum, carry, signed overflow
//   rsp_zero                 - result is zero (only with ADDSUB_SEQ_ZERO_FLAG_EN)
// Optional build macro: ADDSUB_SEQ_ZERO_FLAG_EN.
module addsub_seq_arbiter
  import addsub_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_m,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_m,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_ovf
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  ,
  output logic         rsp_zero
`endif
);
  localparam int NS = W / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;

  if ((W % SLICE) != 0 || W < SLICE) begin : g_bad_width
    $error("addsub_seq_arbiter: W must be a positive multiple of SLICE");
  end

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            id_q, id_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [KW-1:0]   k_q, k_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  logic            zero_q, zero_d;
`endif

  logic             grant;
  logic             sel_m;
  logic [SLICE-1:0] s_a, s_b, s_sum;
  logic             s_cout, s_c_msb;

  // Prefer the requester that did not win last time when both are pending.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;
  assign sel_m      = grant ? req1_m : req0_m;

  assign s_a = a_q[k_q*SLICE +: SLICE];
  assign s_b = b_q[k_q*SLICE +: SLICE];

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a        (s_a),
    .b        (s_b),
    .cin      (carry_q),
    .sum      (s_sum),
    .cout     (s_cout),
    .c_msb_in (s_c_msb)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    k_d          = k_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    zero_d       = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          a_d          = grant ? req1_a : req0_a;
          // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
          b_d          = (grant ? req1_b : req0_b) ^ {W{sel_m}};
          carry_d      = sel_m;
          k_d          = '0;
          id_d         = grant;
          last_grant_d = grant;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
          zero_d       = 1'b1;
`endif
          state_d      = RUN;
        end
      end
      RUN: begin
        sum_d[k_q*SLICE +: SLICE] = s_sum;
        carry_d = s_cout;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q & (s_sum == '0);
`endif
        if (k_q == KW'(NS-1)) begin
          k_d     = '0;
          cout_d  = s_cout;
          ovf_d   = s_c_msb ^ s_cout;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      k_q          <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      zero_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      k_q          <= k_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      zero_q       <= zero_d;
`endif
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  assign rsp_zero  = zero_q;
`endif
endmodule

// File: tb/tb_addsub_seq_arbiter.sv
// Directed bench for addsub_seq_arbiter (W=16, SLICE=4).
module tb_addsub_seq_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_m;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_m;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [15:0] rsp_sum;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_seq_arbiter #(.W(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  // Drive one request, wait for accept, scramble operands, wait for rsp_valid.
  // lat = edges from the accept edge until rsp_valid is seen; -1 on timeout.
  task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic m, output int lat);
    int n;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_m = m; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_m = m; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    lat = -1;
    if (n < 20) begin
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      // Later operand changes must not affect the result.
      req0_a = 16'hDEAD; req0_b = 16'hBEEF; req1_a = 16'hDEAD; req1_b = 16'hBEEF;
      req0_m = ~m; req1_m = ~m;
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      if (rsp_valid) lat = n;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic consume();
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_m = 0; req1_a = 0; req1_b = 0; req1_m = 0;
    rst = 1;
    #12;
    checks++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum, req0_ready, req1_ready} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b id=%b c=%b o=%b s=%h r0=%b r1=%b exp all 0",
               rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum, req0_ready, req1_ready);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith(input string nm, input logic id, input logic [15:0] a,
                            input logic [15:0] b, input logic m, input logic [15:0] es,
                            input logic ec, input logic eo, input logic ez);
    int lat;
    issue(id, a, b, m, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL %s_latency got %0d exp 4", nm, lat);
    end
    checks++;
    if ({rsp_sum, rsp_cout, rsp_ovf, rsp_id} !== {es, ec, eo, id}) begin
      errors++;
      $display("FAIL %s_result got sum=%h c=%b o=%b id=%b exp sum=%h c=%b o=%b id=%b",
               nm, rsp_sum, rsp_cout, rsp_ovf, rsp_id, es, ec, eo, id);
    end
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    checks++;
    if (rsp_zero !== ez) begin
      errors++; $display("FAIL %s_zero got %b exp %b", nm, rsp_zero, ez);
    end
`else
    if (ez === 1'bx) $display("unused");
`endif
    consume();
  endtask

  task automatic test_contention();
    logic exp_id;
    int n;
    test_reset();
    req0_a = 16'h0001; req0_b = 16'h0002; req0_m = 0;
    req1_a = 16'h0010; req1_b = 16'h0004; req1_m = 1;
    req0_valid = 1; req1_valid = 1;
    exp_id = 0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (!rsp_valid || rsp_id !== exp_id || rsp_sum !== (exp_id ? 16'h000C : 16'h0003)) begin
        errors++;
        $display("FAIL contention_op%0d got v=%b id=%b sum=%h exp id=%b sum=%h", i,
                 rsp_valid, rsp_id, rsp_sum, exp_id, exp_id ? 16'h000C : 16'h0003);
      end
      consume();
      exp_id = ~exp_id;
    end
    req0_valid = 0; req1_valid = 0;
    // Let any op accepted during the last handshake drain.
    for (int i = 0; i < 6; i++) begin
      rsp_ready = 1; @(posedge clk); #1;
    end
    rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    int lat;
    issue(0, 16'h1111, 16'h2222, 0, lat);
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (!rsp_valid || rsp_sum !== 16'h3333 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold%0d got v=%b sum=%h id=%b r0=%b r1=%b exp v=1 sum=3333 id=0 r0=0 r1=0",
                 i, rsp_valid, rsp_sum, rsp_id, req0_ready, req1_ready);
      end
    end
    req0_valid = 0; req1_valid = 0;
    consume();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release got v=%b exp 0", rsp_valid);
    end
    req0_valid = 1; #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_idle got r0=%b exp 1", req0_ready);
    end
    req0_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic seen;
    req0_valid = 1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_m = 0;
    #1;
    @(posedge clk); #1;          // accept edge
    req0_valid = 0;
    @(posedge clk); @(posedge clk); #1;  // slices 0 and 1 done
    rst = 1; #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum} !== 20'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs got v=%b id=%b c=%b o=%b s=%h exp 0",
               rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum);
    end
    @(negedge clk); rst = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrun_no_response got seen=%b exp 0", seen);
    end
    test_arith("after_reset", 0, 16'h1234, 16'h0101, 0, 16'h1335, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_arith("add",     0, 16'h000A, 16'h0005, 0, 16'h000F, 0, 0, 0);
    test_arith("sub",     1, 16'h000A, 16'h0003, 1, 16'h0007, 1, 0, 0);
    test_arith("ovf_pos", 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0);
    test_arith("borrow",  1, 16'h0000, 16'h0001, 1, 16'hFFFF, 0, 0, 0);
    test_arith("wrap",    0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1);
    test_arith("ovf_neg", 1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 0);
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
